pattern_playback: RTL and testbench
===================================

Name: pattern_playback

Overview:
- Parametrised successor to the single-RAM PRBS serializer driver.
- Holds a DEPTH x DATA_WIDTH pattern RAM loaded from a write port.
- Plays the pattern back one word per clock to a parallel serializer bus (e.g. SN65LV1023 10-bit input), in one-shot or loop mode, with a periodic sync marker.
- Sits between the host/config logic and the serializer pin bus.

Parameters:
- DATA_WIDTH, 10: bits per pattern word and per data_out.
- ADDR_WIDTH, 11: RAM address width; DEPTH = 2**ADDR_WIDTH.
- SYNC_PERIOD_LOG2, 4: sync asserts once every 2**SYNC_PERIOD_LOG2 output words.
- IDLE_WORD, 0: value driven on data_out whenever data_valid=0.

Ports:
- clock, input, 1: single clock domain; all logic on the rising edge.
- reset_active_low, input, 1: asynchronous, active-low reset.
- write_enable, input, 1: write write_data to write_address this cycle.
- write_address, input, ADDR_WIDTH: RAM write address.
- write_data, input, DATA_WIDTH: RAM write data.
- start, input, 1: begin playback (sampled in IDLE or DONE only).
- stop, input, 1: abort playback.
- loop_mode, input, 1: 1 = wrap forever; 0 = one-shot. Latched at start.
- last_address, input, ADDR_WIDTH: final address played. Latched at start.
- data_out, output, DATA_WIDTH: registered pattern word.
- data_valid, output, 1: data_out holds a pattern word.
- sync, output, 1: marker word, coincident with data_valid.
- busy, output, 1: state is FILL or PLAY.
- done, output, 1: one-cycle pulse at the end of one-shot playback.
- write_error, output, 1: one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async assert): state=IDLE (FILL if PRBS_FILL_EN), data_out=IDLE_WORD, all other outputs 0, address and sync counters 0. RAM contents are not cleared.
- States:
  - IDLE: start=1 latches loop_mode and last_address, read address=0, go to PLAY.
  - PLAY: read address increments each clock.
    - At last_address with loop_mode=1: wrap to 0, stay in PLAY.
    - At last_address with loop_mode=0: go to DONE.
  - DONE: done pulses for one cycle on entry; start behaves as in IDLE; otherwise go to IDLE.
- Latency: start sampled at edge N gives data_out=mem[0], data_valid=1 after edge N+2 (one cycle synchronous RAM read, one cycle output register). After that, one word per clock with no gaps.
- One-shot: exactly last_address+1 valid words. done pulses in the cycle after the last valid word.
- last_address=0: one word (one-shot) or mem[0] repeated every cycle (loop).
- sync:
  - Free-running word counter of width SYNC_PERIOD_LOG2, cleared at start, incremented per valid word.
  - sync=1 when the counter is 0 and data_valid=1. The first word after start is always sync.
  - The counter is independent of RAM address, so the phase carries across loop wraps.
- stop (priority over start):
  - In PLAY: no further reads are issued; words already in the pipeline are discarded; data_valid=0 from the next edge; go to IDLE with no done pulse.
  - In other states: ignored.
- Writes:
  - Accepted in IDLE and DONE.
  - In PLAY or FILL: ignored, RAM unchanged, write_error pulses.
- Simultaneous events:
  - Same-cycle write and start in IDLE: the write completes, and the word read at that address reflects the new data (the write precedes the first read by one cycle).
  - start while busy: ignored, no error.
- data_out returns to IDLE_WORD whenever data_valid=0.
- Async reset mid-PLAY: outputs drop immediately to their reset values.

Optional Feature:
- Macro: PATTERN_PLAYBACK_PRBS_FILL_EN.
- Defined:
  - After reset release, state FILL writes all DEPTH words, one per clock, then goes to IDLE; busy=1 throughout.
  - Generator: 31-bit Fibonacci LFSR, seed 31'h1, new bit = s[30]^s[27] shifted into bit 0.
  - Word i = s[DATA_WIDTH-1:0] after i steps, giving 1, 2, 4, 8, ...
  - start and external writes are ignored during FILL; writes pulse write_error.
- Undefined: no FILL state, no LFSR; reset goes straight to IDLE.

Test Plan:
- Write mem[0..3]=10'h101,10'h202,10'h303,10'h3FF; one-shot with last_address=3 -> data_out 101,202,303,3FF on edges N+2..N+5, sync on the 101 word only, done pulse at N+6, busy low afterwards.
- Same pattern with loop_mode=1 for 40 cycles -> continuous 101..3FF repetition, sync every 16th word (words 0,16,32), no done.
- Loop running, stop asserted at word 7 -> data_valid=0 and data_out=IDLE_WORD from the next edge, state IDLE, no done; a restart gives mem[0] first with sync.
- write_enable during PLAY to address 2 with 10'h0AA -> write_error pulse; a later playback still shows 10'h303 at word 2.
- reset_active_low pulled low mid-PLAY, asynchronous to clock -> all outputs 0/IDLE_WORD immediately; after release, start gives correct playback.
- With PATTERN_PLAYBACK_PRBS_FILL_EN and ADDR_WIDTH=4 -> busy for 16 cycles; then one-shot with last_address=15 gives 001,002,004,...,200, then LFSR-continued values.

Source files
------------

// File: rtl/pattern_playback_if.sv
// ---------------------------------------------------------------------------
// pattern_playback_if
//
// Groups the host-side control/write signals and the serializer-side output
// bus of pattern_playback into one bundle.
//
//   write_enable/write_address/write_data : pattern RAM write port
//   start/stop/loop_mode/last_address     : playback control
//   data_out/data_valid/sync              : parallel serializer bus
//   busy/done/write_error                 : status back to the host
//
// Modports:
//   master : host/config side (drives control and writes, observes status)
//   slave  : the playback engine itself
// ---------------------------------------------------------------------------
interface pattern_playback_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 11
);
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  start;
    logic                  stop;
    logic                  loop_mode;
    logic [ADDR_WIDTH-1:0] last_address;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  sync;
    logic                  busy;
    logic                  done;
    logic                  write_error;

    modport master (
        output write_enable, write_address, write_data,
        output start, stop, loop_mode, last_address,
        input  data_out, data_valid, sync, busy, done, write_error
    );

    modport slave (
        input  write_enable, write_address, write_data,
        input  start, stop, loop_mode, last_address,
        output data_out, data_valid, sync, busy, done, write_error
    );
endinterface

// File: rtl/pattern_playback.sv
// ---------------------------------------------------------------------------
// pattern_playback
//
// Holds a DEPTH x DATA_WIDTH pattern RAM loaded through a write port and
// plays it back one word per clock onto a parallel serializer bus, either
// once (one-shot) or wrapping forever (loop), with a sync marker every
// 2**SYNC_PERIOD_LOG2 output words.
//
// Ports:
//   clock            : single clock, rising edge
//   reset_active_low : asynchronous active-low reset
//   bus (slave)      : write port, playback control and output bus
//                      (see pattern_playback_if)
//
// Optional feature (macro PATTERN_PLAYBACK_PRBS_FILL_EN):
//   after reset the RAM is filled with a 31-bit Fibonacci LFSR sequence
//   (seed 1, feedback s[30]^s[27]) before the engine becomes idle.
//
// Pipeline: start at edge N -> RAM read at N+1 -> data_out at N+2.
// ---------------------------------------------------------------------------
module pattern_playback #(
    parameter int                    DATA_WIDTH       = 10,
    parameter int                    ADDR_WIDTH       = 11,
    parameter int                    SYNC_PERIOD_LOG2 = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD        = '0
) (
    input  logic              clock,
    input  logic              reset_active_low,
    pattern_playback_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE,
        ST_FILL
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]       last_addr_q, last_addr_d;
    logic                        loop_q, loop_d;
    logic                        issuing_q, issuing_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_last_q, rd_last_d;
    logic                        out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]       data_out_q, data_out_d;
    logic                        data_valid_q, data_valid_d;
    logic                        sync_q, sync_d;
    logic                        done_q, done_d;
    logic                        write_error_q, write_error_d;
    logic [SYNC_PERIOD_LOG2-1:0] sync_cnt_q, sync_cnt_d;
`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
    logic [30:0]                 lfsr_q, lfsr_d;
`endif

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [DATA_WIDTH-1:0]       ram_rdata;
    logic                        ram_we;
    logic [ADDR_WIDTH-1:0]       ram_waddr;
    logic [DATA_WIDTH-1:0]       ram_wdata;
    logic                        busy;

    assign busy = (state_q == ST_PLAY) || (state_q == ST_FILL);

    // Pattern RAM: one write port, one registered read port. The read always
    // follows addr_q; rd_valid_q says whether that read belongs to playback.
    // Contents survive reset on purpose.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= mem[addr_q];
    end

    // Next-state and output logic. The pipeline stages carry a valid bit and
    // a "last word" tag so the one-shot done pulse lands in the cycle right
    // after the final word leaves the output register. PLAY therefore spans
    // the pipeline drain, which keeps busy high until the last word is out.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        last_addr_d   = last_addr_q;
        loop_d        = loop_q;
        issuing_d     = issuing_q;
        rd_valid_d    = 1'b0;
        rd_last_d     = 1'b0;
        out_last_d    = rd_last_q;
        data_valid_d  = rd_valid_q;
        data_out_d    = rd_valid_q ? ram_rdata : IDLE_WORD;
        sync_d        = rd_valid_q && (sync_cnt_q == '0);
        sync_cnt_d    = rd_valid_q ? sync_cnt_q + 1'b1 : sync_cnt_q;
        done_d        = 1'b0;
        write_error_d = bus.write_enable && busy;
        ram_we        = bus.write_enable && !busy;
        ram_waddr     = bus.write_address;
        ram_wdata     = bus.write_data;
`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
        lfsr_d        = lfsr_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    state_d     = ST_PLAY;
                    addr_d      = '0;
                    last_addr_d = bus.last_address;
                    loop_d      = bus.loop_mode;
                    issuing_d   = 1'b1;
                    sync_cnt_d  = '0;
                end
            end

            ST_PLAY: begin
                if (bus.stop) begin
                    state_d      = ST_IDLE;
                    issuing_d    = 1'b0;
                    data_valid_d = 1'b0;
                    data_out_d   = IDLE_WORD;
                    sync_d       = 1'b0;
                    out_last_d   = 1'b0;
                end else begin
                    if (issuing_q) begin
                        rd_valid_d = 1'b1;
                        if (addr_q == last_addr_q) begin
                            if (loop_q) begin
                                addr_d = '0;
                            end else begin
                                issuing_d = 1'b0;
                                rd_last_d = 1'b1;
                            end
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                    if (out_last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
            // addr_q doubles as the fill pointer; it is back at 0 on exit.
            ST_FILL: begin
                ram_we    = 1'b1;
                ram_waddr = addr_q;
                ram_wdata = lfsr_q[DATA_WIDTH-1:0];
                lfsr_d    = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
                addr_d    = addr_q + 1'b1;
                if (&addr_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; everything observable drops at once on
    // reset assertion.
    always_ff @(posedge clock or negedge reset_active_low) begin
        if (!reset_active_low) begin
`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
            state_q       <= ST_FILL;
            lfsr_q        <= 31'h1;
`else
            state_q       <= ST_IDLE;
`endif
            addr_q        <= '0;
            last_addr_q   <= '0;
            loop_q        <= 1'b0;
            issuing_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            out_last_q    <= 1'b0;
            data_out_q    <= IDLE_WORD;
            data_valid_q  <= 1'b0;
            sync_q        <= 1'b0;
            done_q        <= 1'b0;
            write_error_q <= 1'b0;
            sync_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
            lfsr_q        <= lfsr_d;
`endif
            addr_q        <= addr_d;
            last_addr_q   <= last_addr_d;
            loop_q        <= loop_d;
            issuing_q     <= issuing_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
            out_last_q    <= out_last_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            sync_q        <= sync_d;
            done_q        <= done_d;
            write_error_q <= write_error_d;
            sync_cnt_q    <= sync_cnt_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.sync        = sync_q;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.write_error = write_error_q;
endmodule

// File: tb/tb_pattern_playback.sv
// ---------------------------------------------------------------------------
// tb_pattern_playback
//
// Self-checking bench for pattern_playback. A model RAM array mirrors every
// write the design should accept; expected playback is word k = model[k mod
// (last+1)], sync when k mod 16 == 0, first word two edges after start.
// Honours PATTERN_PLAYBACK_PRBS_FILL_EN when defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pattern_playback;
    localparam int DW    = 10;
    localparam int AW    = 11;
    localparam int SPL   = 4;
    localparam int DEPTH = 2 ** AW;
    localparam logic [DW-1:0] IDLE_W = '0;
`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
    localparam int RESET_BUSY = 1;
`else
    localparam int RESET_BUSY = 0;
`endif

    logic clock = 1'b0;
    logic reset_active_low = 1'b0;

    pattern_playback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pattern_playback #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .SYNC_PERIOD_LOG2(SPL),
        .IDLE_WORD(IDLE_W)
    ) dut (
        .clock(clock),
        .reset_active_low(reset_active_low),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] model_mem [DEPTH];

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input int addr, input int data, input logic st,
                                 input logic sp, input logic lp, input int last);
        bus.write_enable  = we;
        bus.write_address = AW'(addr);
        bus.write_data    = DW'(data);
        bus.start         = st;
        bus.stop          = sp;
        bus.loop_mode     = lp;
        bus.last_address  = AW'(last);
    endtask

    // Advance one clock and land 1ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic writeWord(input int addr, input int data);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0, 0);
        model_mem[addr] = DW'(data);
        step();
        checkOutput("idle_write_err", bus.write_error, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Runs after reset release (clock phase: 3ns past a rising edge).
    task automatic afterRelease();
`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
        int n;
        logic [30:0] s;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.busy && n < DEPTH + 8);
        checkOutput("fill_cycles", n, DEPTH);
        s = 31'h1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = s[DW-1:0];
            s = {s[29:0], s[30] ^ s[27]};
        end
`else
        step();
        checkOutput("post_reset_busy", bus.busy, 0);
`endif
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_data"}, bus.data_out, IDLE_W);
        checkOutput({tag, "_valid"}, bus.data_valid, 0);
        checkOutput({tag, "_sync"}, bus.sync, 0);
        checkOutput({tag, "_busy"}, bus.busy, RESET_BUSY);
        checkOutput({tag, "_done"}, bus.done, 0);
        checkOutput({tag, "_werr"}, bus.write_error, 0);
    endtask

    // One playback: start, then check every output cycle against the model.
    //   injMode 0: quiet; 1: write 0AA to address 2 every word; 2: random
    //   writes and start pulses while busy. stopAt<0 means no stop.
    //   withWrite: a write to an address inside the pattern shares the start cycle.
    task automatic playAndCheck(input int last, input bit loopm, input int nWords,
                                input int stopAt, input int injMode, input bit withWrite);
        int total;
        int wa;
        int wd;
        bit pend;
        logic [DW-1:0] expw;
        if (withWrite) begin
            wa = $urandom_range(0, last);
            wd = int'($urandom);
            model_mem[wa] = DW'(wd);
            applyStimulus(1'b1, wa, wd, 1'b1, 1'b0, loopm, last);
        end else begin
            applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, loopm, last);
        end
        step();
        checkOutput("start_busy", bus.busy, 1);
        checkOutput("start_werr", bus.write_error, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, ~loopm, int'($urandom));
        step();
        checkOutput("pipe_valid", bus.data_valid, 0);
        pend = 1'b0;
        total = loopm ? nWords : last + 1;
        for (int k = 0; k < total; k++) begin
            step();
            expw = model_mem[k % (last + 1)];
            checkOutput("word_valid", bus.data_valid, 1);
            checkOutput("word_data", bus.data_out, expw);
            checkOutput("word_sync", bus.sync, ((k % 16) == 0) ? 1 : 0);
            checkOutput("word_done", bus.done, 0);
            checkOutput("word_busy", bus.busy, 1);
            checkOutput("word_werr", bus.write_error, pend);
            pend = 1'b0;
            if (k == stopAt) begin
                applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0);
                step();
                applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
                checkOutput("stop_valid", bus.data_valid, 0);
                checkOutput("stop_data", bus.data_out, IDLE_W);
                checkOutput("stop_sync", bus.sync, 0);
                checkOutput("stop_busy", bus.busy, 0);
                checkOutput("stop_done", bus.done, 0);
                step();
                checkOutput("stop_valid2", bus.data_valid, 0);
                checkOutput("stop_done2", bus.done, 0);
                return;
            end
            if (injMode == 1) begin
                applyStimulus(1'b1, 2, 'h0AA, 1'b0, 1'b0, ~loopm, int'($urandom));
                pend = 1'b1;
            end else if (injMode == 2 && $urandom_range(0, 2) == 0) begin
                applyStimulus(1'b1, $urandom_range(0, 63), int'($urandom), 1'($urandom_range(0, 1)),
                              1'b0, ~loopm, int'($urandom));
                pend = 1'b1;
            end else begin
                applyStimulus(1'b0, 0, 0, 1'($urandom_range(0, 1) & (injMode == 2)), 1'b0, 1'b0, 0);
            end
        end
        step();
        checkOutput("done_pulse", bus.done, 1);
        checkOutput("done_valid", bus.data_valid, 0);
        checkOutput("done_data", bus.data_out, IDLE_W);
        checkOutput("done_busy", bus.busy, 0);
        checkOutput("done_werr", bus.write_error, pend);
        wa = $urandom_range(0, 63);
        wd = int'($urandom);
        model_mem[wa] = DW'(wd);
        applyStimulus(1'b1, wa, wd, 1'b0, 1'b0, 1'b0, 0);
        step();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        checkOutput("after_done_pulse", bus.done, 0);
        checkOutput("done_write_err", bus.write_error, 0);
        checkOutput("after_done_valid", bus.data_valid, 0);
    endtask

    // Pull reset in the middle of a loop playback, off the clock edge.
    task automatic asyncResetTest();
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 5);
        step();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 5);
        repeat (8) step();
        checkOutput("pre_reset_valid", bus.data_valid, 1);
        #2 reset_active_low = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        @(posedge clock);
        #3 reset_active_low = 1'b1;
        afterRelease();
        playAndCheck(5, 1'b0, 0, -1, 0, 1'b0);
    endtask

    int rl;
    int rn;
    int rs;
    bit rlp;

    initial begin
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        #12;
        checkResetOutputs("reset");
        @(posedge clock);
        #3 reset_active_low = 1'b1;
        afterRelease();

`ifdef PATTERN_PLAYBACK_PRBS_FILL_EN
        playAndCheck(15, 1'b0, 0, -1, 0, 1'b0);
`endif

        for (int i = 0; i < 64; i++) begin
            writeWord(i, int'($urandom));
        end

        writeWord(0, 'h101);
        writeWord(1, 'h202);
        writeWord(2, 'h303);
        writeWord(3, 'h3FF);
        playAndCheck(3, 1'b0, 0, -1, 0, 1'b0);
        playAndCheck(3, 1'b1, 40, 39, 0, 1'b0);
        playAndCheck(3, 1'b1, 20, 7, 0, 1'b0);
        playAndCheck(3, 1'b0, 0, -1, 0, 1'b0);
        playAndCheck(3, 1'b1, 6, 5, 1, 1'b0);
        playAndCheck(3, 1'b0, 0, -1, 0, 1'b0);
        checkOutput("protected_word2", model_mem[2], 'h303);

        playAndCheck(0, 1'b0, 0, -1, 0, 1'b0);
        playAndCheck(0, 1'b1, 10, 9, 0, 1'b0);
        playAndCheck(7, 1'b0, 0, -1, 0, 1'b1);

        for (int it = 0; it < 25; it++) begin
            rl  = $urandom_range(0, 40);
            rlp = 1'($urandom_range(0, 1));
            rn  = $urandom_range(1, 60);
            if (rlp) begin
                rs = rn - 1;
            end else if ($urandom_range(0, 3) == 0) begin
                rs = $urandom_range(0, rl);
            end else begin
                rs = -1;
            end
            playAndCheck(rl, rlp, rn, rs, 2, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                writeWord($urandom_range(0, 63), int'($urandom));
            end
        end

        asyncResetTest();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
